// File: rtl/stage_sequencer.sv
// stage_sequencer: multi-cycle instruction sequencer producing the 3-bit Stage
// code (0 idle, 1..5 Fetch..Write Back, 7 halted) for the downstream
// stage-enable decoder. It supports run, single-step, halt and wait-timeout,
// and keeps debug counters for retired instructions and memory stall cycles.
module stage_sequencer #(
  parameter int COUNT_WIDTH = 16,
  parameter int MAX_WAIT    = 15
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   Run,
  input  logic                   Step,
  input  logic                   Mem_Wait,
  input  logic                   HALT_FLAG,
  input  logic                   Resume,
  output logic [2:0]             Stage,
  output logic                   Instr_Retired,
  output logic [COUNT_WIDTH-1:0] Instr_Count,
  output logic [COUNT_WIDTH-1:0] Stall_Count,
  output logic                   Running,
  output logic                   Halted,
  output logic                   Timeout
);

  // The state encoding equals the Stage code, so Stage is the state register.
  // Code 6 is never entered; it only appears through corruption and recovers.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_MEMORY    = 3'd4,
    ST_WRITEBACK = 3'd5,
    ST_HALT      = 3'd7
  } state_e;

  localparam logic [7:0]             MAX_WAIT_C = 8'(MAX_WAIT);
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE    = COUNT_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX    = {COUNT_WIDTH{1'b1}};

  state_e                 state_q, state_d;
  logic                   step_q, step_d;
  logic [7:0]             wait_q, wait_d;
  logic [COUNT_WIDTH-1:0] instr_q, instr_d;
  logic [COUNT_WIDTH-1:0] stall_q, stall_d;
  logic                   timeout_q, timeout_d;

  // Saturating increment for the stall counter.
  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
    if (v == CNT_MAX) begin
      return v;
    end else begin
      return v + CNT_ONE;
    end
  endfunction

  // State and counter registers with asynchronous active-high reset.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      step_q    <= 1'b0;
      wait_q    <= 8'd0;
      instr_q   <= '0;
      stall_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      wait_q    <= wait_d;
      instr_q   <= instr_d;
      stall_q   <= stall_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state logic: stage progression, memory-wait holds, timeout, halt.
  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    wait_d    = 8'd0;
    instr_d   = instr_q;
    stall_d   = stall_q;
    timeout_d = timeout_q;

    case (state_q)
      ST_IDLE: begin
        if (Run) begin
          state_d = ST_FETCH;
          step_d  = 1'b0;
        end else if (Step) begin
          state_d = ST_FETCH;
          step_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_FETCH, ST_MEMORY: begin
        if (Mem_Wait) begin
          if (wait_q == MAX_WAIT_C) begin
            // Wait budget exhausted: abandon the instruction without
            // counting this edge as a stall.
            state_d   = ST_HALT;
            timeout_d = 1'b1;
          end else begin
            state_d = state_q;
            wait_d  = wait_q + 8'd1;
            stall_d = sat_inc(stall_q);
          end
        end else if (state_q == ST_FETCH) begin
          state_d = ST_DECODE;
        end else begin
          state_d = ST_WRITEBACK;
        end
      end

      ST_DECODE: begin
        state_d = ST_EXECUTE;
      end

      ST_EXECUTE: begin
        state_d = ST_MEMORY;
      end

      ST_WRITEBACK: begin
        instr_d = instr_q + CNT_ONE;
        if (HALT_FLAG) begin
          state_d = ST_HALT;
        end else if (step_q) begin
          state_d = ST_IDLE;
          step_d  = 1'b0;
        end else if (Run) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_HALT: begin
        if (Resume) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b0;
        end else begin
          state_d = ST_HALT;
        end
      end

      default: begin
        state_d = ST_IDLE;
        step_d  = 1'b0;
      end
    endcase
  end

  assign Stage         = state_q;
  assign Instr_Count   = instr_q;
  assign Stall_Count   = stall_q;
  assign Timeout       = timeout_q;
  assign Instr_Retired = (state_q == ST_WRITEBACK);
  assign Halted        = (state_q == ST_HALT);
  assign Running       = (state_q == ST_FETCH)   || (state_q == ST_DECODE) ||
                         (state_q == ST_EXECUTE) || (state_q == ST_MEMORY) ||
                         (state_q == ST_WRITEBACK);

endmodule

// File: tb/tb_stage_sequencer.sv
// Testbench for stage_sequencer: directed scenarios followed by randomized
// stimulus, every cycle compared against a behavioural model of the sequencer.
module tb_stage_sequencer;

  localparam int CW   = 6;
  localparam int MW   = 15;
  localparam int CMAX = (1 << CW) - 1;

  logic          Clock = 1'b0;
  logic          Reset = 1'b1;
  logic          Run = 1'b0, Step = 1'b0, Mem_Wait = 1'b0, HALT_FLAG = 1'b0, Resume = 1'b0;
  logic [2:0]    Stage;
  logic          Instr_Retired, Running, Halted, Timeout;
  logic [CW-1:0] Instr_Count, Stall_Count;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int m_stage, m_wait, m_instr, m_stall;
  bit m_stepf, m_to;

  stage_sequencer #(.COUNT_WIDTH(CW), .MAX_WAIT(MW)) dut (
    .Clock(Clock), .Reset(Reset), .Run(Run), .Step(Step), .Mem_Wait(Mem_Wait),
    .HALT_FLAG(HALT_FLAG), .Resume(Resume), .Stage(Stage),
    .Instr_Retired(Instr_Retired), .Instr_Count(Instr_Count),
    .Stall_Count(Stall_Count), .Running(Running), .Halted(Halted), .Timeout(Timeout)
  );

  // 10 ns clock
  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_stage = 0; m_wait = 0; m_instr = 0; m_stall = 0; m_stepf = 0; m_to = 0;
  endtask

  // One clock edge of the sequencer rules, in plain arithmetic.
  task automatic model_update();
    int ns;
    ns = m_stage;
    case (m_stage)
      0: begin
        if (Run) begin ns = 1; m_stepf = 0; end
        else if (Step) begin ns = 1; m_stepf = 1; end
      end
      1, 4: begin
        if (Mem_Wait) begin
          if (m_wait == MW) begin ns = 7; m_to = 1; end
          else begin m_wait++; m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX; end
        end else ns = m_stage + 1;
      end
      2, 3: ns = m_stage + 1;
      5: begin
        m_instr = (m_instr + 1) % (CMAX + 1);
        if (HALT_FLAG) ns = 7;
        else if (m_stepf) begin ns = 0; m_stepf = 0; end
        else if (Run) ns = 1;
        else ns = 0;
      end
      7: if (Resume) begin ns = 0; m_to = 0; end
      default: ns = 0;
    endcase
    if (ns != m_stage) m_wait = 0;
    m_stage = ns;
  endtask

  task automatic check_all();
    chk("stage", Stage, m_stage);
    chk("instr_count", Instr_Count, m_instr);
    chk("stall_count", Stall_Count, m_stall);
    chk("timeout", Timeout, m_to);
    chk("running", Running, (m_stage >= 1 && m_stage <= 5));
    chk("halted", Halted, (m_stage == 7));
    chk("instr_retired", Instr_Retired, (m_stage == 5));
  endtask

  // Inputs change 1 ns after the edge; outputs are checked at that point too.
  task automatic tick();
    @(posedge Clock);
    model_update();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    #2;
    model_reset();
    check_all();
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    check_all();
  endtask

  task automatic wait_stage(input int s, input int limit);
    int n = 0;
    while (m_stage != s && n < limit) begin
      tick();
      n++;
    end
    if (m_stage != s) begin
      n_checks++;
      n_fail++;
      $error("FAIL wait_stage: stage %0d not reached within %0d cycles", s, limit);
    end
  endtask

  task automatic timeout_run();
    int st0, in0;
    st0 = m_stall; in0 = m_instr;
    Step = 1'b1; Mem_Wait = 1'b1;
    tick();
    Step = 1'b0;
    for (int i = 0; i < MW; i++) tick();
    chk("to_hold_stage", Stage, 1);
    tick();
    chk("to_stage", Stage, 7);
    chk("to_flag", Timeout, 1);
    chk("to_halted", Halted, 1);
    chk("to_instr", Instr_Count, in0);
    chk("to_stall", Stall_Count, (st0 + MW > CMAX) ? CMAX : st0 + MW);
    Mem_Wait = 1'b0; Resume = 1'b1;
    tick();
    Resume = 1'b0;
    chk("resume_stage", Stage, 0);
    chk("resume_timeout", Timeout, 0);
  endtask

  initial begin
    int ret_cnt, s4_cnt, base, burst;

    // A: reset state
    #1;
    do_reset();

    // B: Run held; the first edge leaves IDLE, so 16 edges retire 3 instructions
    Run = 1'b1;
    for (int i = 0; i < 16; i++) tick();
    chk("run_instr3", Instr_Count, 3);
    chk("run_stall0", Stall_Count, 0);

    // C: single step, with a second Step during Execute ignored
    Run = 1'b0;
    wait_stage(0, 10);
    base = m_instr; ret_cnt = 0;
    Step = 1'b1;
    tick(); ret_cnt += Instr_Retired;
    Step = 1'b0;
    tick(); ret_cnt += Instr_Retired;
    tick(); ret_cnt += Instr_Retired;
    chk("step_exec", Stage, 3);
    Step = 1'b1;
    tick(); ret_cnt += Instr_Retired;
    Step = 1'b0;
    for (int i = 0; i < 4; i++) begin tick(); ret_cnt += Instr_Retired; end
    chk("step_idle", Stage, 0);
    chk("step_instr", Instr_Count, (base + 1) % (CMAX + 1));
    chk("step_retired_once", ret_cnt, 1);

    // D: three wait cycles in Memory, then Mem_Wait in Decode is ignored
    Run = 1'b1;
    wait_stage(4, 20);
    base = m_stall; s4_cnt = 1;
    Mem_Wait = 1'b1;
    for (int i = 0; i < 3; i++) begin tick(); s4_cnt += (Stage == 3'd4); end
    Mem_Wait = 1'b0;
    tick(); s4_cnt += (Stage == 3'd4);
    chk("mem_hold_cycles", s4_cnt, 4);
    chk("mem_stall3", Stall_Count, base + 3);
    wait_stage(2, 20);
    Mem_Wait = 1'b1;
    tick();
    Mem_Wait = 1'b0;
    chk("decode_no_hold", Stage, 3);
    chk("decode_no_stall", Stall_Count, base + 3);

    // E: HALT_FLAG in Write Back; Run and Step then ignored until Resume
    wait_stage(5, 20);
    base = m_instr;
    HALT_FLAG = 1'b1;
    tick();
    HALT_FLAG = 1'b0;
    chk("halt_stage", Stage, 7);
    chk("halt_instr", Instr_Count, (base + 1) % (CMAX + 1));
    Step = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    Step = 1'b0;
    chk("halt_sticky", Stage, 7);
    Run = 1'b0; Resume = 1'b1;
    tick();
    Resume = 1'b0;
    chk("halt_resume", Stage, 0);

    // F: asynchronous reset in the middle of Execute
    Run = 1'b1;
    wait_stage(3, 20);
    Run = 1'b0;
    #2;
    Reset = 1'b1;
    #1;
    chk("areset_stage", Stage, 0);
    chk("areset_instr", Instr_Count, 0);
    chk("areset_stall", Stall_Count, 0);
    model_reset();
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    check_all();

    // G: repeated timeouts drive the stall counter into saturation
    for (int k = 0; k < 5; k++) timeout_run();
    chk("stall_saturated", Stall_Count, CMAX);

    // H: instruction counter reaches all-ones and wraps to zero
    do_reset();
    Run = 1'b1;
    for (int i = 0; i < 1 + 5 * CMAX; i++) tick();
    chk("instr_all_ones", Instr_Count, CMAX);
    for (int i = 0; i < 5; i++) tick();
    chk("instr_wrap", Instr_Count, 0);
    Run = 1'b0;

    // I: randomized stimulus against the model
    burst = 0;
    for (int i = 0; i < 3000; i++) begin
      Run       = ($urandom_range(0, 99) < 55);
      Step      = ($urandom_range(0, 99) < 10);
      HALT_FLAG = ($urandom_range(0, 99) < 8);
      Resume    = ($urandom_range(0, 99) < 15);
      if (burst > 0) begin
        Mem_Wait = 1'b1;
        burst--;
      end else if ($urandom_range(0, 99) < 4) begin
        burst = $urandom_range(3, 20);
        Mem_Wait = 1'b1;
      end else begin
        Mem_Wait = ($urandom_range(0, 99) < 25);
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stage_sequencer.md
Name: stage_sequencer

Overview:
Multi-cycle instruction sequencer that generates the 3-bit Stage code consumed by the stage-enable decoder directly downstream. Stage steps Fetch(1), Decode(2), Execute(3), Memory(4), Write Back(5). It holds in Fetch or Memory while memory signals wait, and supports run, single-step, halt and wait-timeout. It also keeps retired-instruction and stall counters for debug.

Parameters:
COUNT_WIDTH, 16, width of Instr_Count and Stall_Count
MAX_WAIT, 15, maximum consecutive wait cycles tolerated in one stage before timeout (1..255)

Ports:
Clock  input  1  system clock, rising-edge
Reset  input  1  asynchronous, active-high; returns block to IDLE immediately
Run  input  1  level; 1 = continuous execution
Step  input  1  one-cycle pulse; executes exactly one instruction from IDLE
Mem_Wait  input  1  memory not ready; honoured only in stages 1 and 4
HALT_FLAG  input  1  decoded halt instruction; sampled only in stage 5
Resume  input  1  one-cycle pulse; leaves HALT
Stage  output  3  0 = idle, 1..5 = pipeline stage, 7 = halted
Instr_Retired  output  1  high during every stage-5 cycle
Instr_Count  output  COUNT_WIDTH  retired instructions, wrapping
Stall_Count  output  COUNT_WIDTH  total Mem_Wait hold cycles, saturating
Running  output  1  1 while Stage is in 1..5
Halted  output  1  1 while in HALT
Timeout  output  1  sticky; set on wait timeout, cleared by Resume or Reset

Behaviour:
- Reset (async, active-high):
  - State IDLE; Stage = 0.
  - Instr_Count, Stall_Count, wait counter = 0.
  - Timeout = 0, single-step mode flag = 0.
  - Running = 0, Halted = 0, Instr_Retired = 0.
- All outputs except Instr_Retired, Running and Halted are registered. Those three decode combinationally from the registered state.
- IDLE (Stage = 0):
  - Run = 1: next state FETCH, step flag = 0.
  - Else Step = 1: next state FETCH, step flag = 1.
  - Run has priority when both are asserted.
- Stage advance: 1→2→3→4→5, one cycle each.
  - Exception: in stage 1 or stage 4, if Mem_Wait = 1 at the clock edge, Stage holds, wait counter increments and Stall_Count increments (saturating at all-ones).
  - Mem_Wait is ignored in stages 2, 3 and 5.
- Wait counter:
  - Clears on every stage change.
  - If wait counter = MAX_WAIT and Mem_Wait = 1 at an edge: next state HALT, Timeout = 1, and the instruction is abandoned (Instr_Count unchanged).
  - Exactly MAX_WAIT hold cycles are permitted. The timeout edge itself does not increment Stall_Count.
- Leaving stage 5, in priority order:
  - Instr_Count increments (wraps from all-ones to 0).
  - HALT_FLAG = 1: go to HALT.
  - Else step flag = 1: go to IDLE and clear the step flag.
  - Else Run = 1: go to FETCH (back-to-back, no idle bubble).
  - Else: go to IDLE.
- Run deasserted mid-instruction: the current instruction completes through stage 5, then IDLE.
- Step while not in IDLE: ignored; it is not queued.
- HALT (Stage = 7):
  - Run and Step are ignored.
  - Resume = 1: go to IDLE and clear Timeout.
  - Resume in any other state: ignored.
- Stage codes 0 and 7 both map to all-enables-off downstream. No other out-of-range code is ever produced.
- Illegal state encodings recover to IDLE on the next edge.

Test Plan:
- Reset, Run = 1 held, Mem_Wait = 0 → Stage sequence 1,2,3,4,5,1,2…; Instr_Count = 3 after 15 cycles; Stall_Count = 0.
- IDLE, Step pulse → Stage 1..5 once, then 0; Instr_Count = 1; Instr_Retired high for exactly 1 cycle; a second Step during stage 3 has no effect.
- Run = 1; Mem_Wait = 1 for 3 cycles in stage 4 → Stage 4 held for 4 cycles total; Stall_Count = 3; Mem_Wait = 1 in stage 2 → no hold.
- Mem_Wait held high in stage 1 with MAX_WAIT = 15:
  - After 15 holds, the next edge gives Stage = 7, Timeout = 1, Halted = 1, Instr_Count unchanged.
  - Resume → Stage = 0, Timeout = 0.
- HALT_FLAG = 1 during stage 5 with Run = 1 → Stage = 7 and Instr_Count incremented; Run then has no effect until Resume.
- Reset asserted during stage 3 with counts nonzero → Stage = 0 and counters = 0 asynchronously, before the next edge; Instr_Count preset to all-ones retires → 0.
